ccff_chain_loader: RTL and testbench

//   Configuration sequencer for a CLB tile's configuration flip-flop (ccff) chain.

---
 rtl/ccff_loader_pkg.sv | 17 +
 rtl/ccff_crc8.sv | 41 ++++
 rtl/ccff_chain_loader.sv | 203 ++++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
//   Shared definitions for the ccff chain loader: the FSM state encoding and the
//   CRC-8 constants used when the optional checksum (CCFF_CHECKSUM_EN) is built in.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/ccff_crc8.sv
// ccff_crc8
//   Serial CRC-8 (MSB-first register, no reflection, no final xor). Absorbs one
//   bit per cycle while bit_en is high; clear reloads the init value.
// Ports
//   clk      in  configuration clock
//   reset    in  asynchronous, active-high reset
//   clear    in  reload CRC8_INIT (has priority over bit_en)
//   bit_in   in  serial data bit
//   bit_en   in  absorb bit_in this cycle
//   crc_out  out current CRC value
module ccff_crc8
  import ccff_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       bit_in,
  input  logic       bit_en,
  output logic [7:0] crc_out
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[7] ^ bit_in;
    if (clear)
      crc_d = CRC8_INIT;
    else if (bit_en)
      crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) crc_q <= CRC8_INIT;
    else       crc_q <= crc_d;
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Configuration sequencer for a CLB tile's ccff chain. Accepts bitstream words
//   over a valid/ready stream and serializes them LSB first onto ccff_head, one
//   bit per cycle, with shift_en marking exactly CHAIN_LEN chain-shift cycles.
//   Optional feature macro: CCFF_CHECKSUM_EN -- after the last bit, one extra
//   word is accepted whose bits [7:0] must equal the CRC-8 of all shifted bits;
//   a mismatch sets cfg_error.
// Ports
//   prog_clk   in   configuration clock (rising edge)
//   prog_reset in   asynchronous, active-high reset
//   cfg_start  in   begin a load (IDLE/DONE only)
//   cfg_abort  in   abandon a load in progress, flags cfg_error
//   bs_data    in   bitstream word, LSB shifted first
//   bs_valid   in   bs_data valid
//   bs_ready   out  word accepted on bs_valid & bs_ready
//   ccff_head  out  serial bit to the chain head
//   shift_en   out  chain-clock enable for this cycle
//   ccff_tail  in   chain tail (not consumed by this implementation)
//   cfg_busy   out  load in progress
//   cfg_done   out  load complete
//   cfg_error  out  sticky error, cleared by the next accepted cfg_start
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 29,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_error
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WL_W  = $clog2(WORD_W + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bits_left_q, bits_left_d;
  logic [WL_W-1:0]     word_left_q, word_left_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                bs_ready_q, bs_ready_d;
  logic                ccff_head_q, ccff_head_d;
  logic                shift_en_q, shift_en_d;
  logic                cfg_busy_q, cfg_busy_d;
  logic                cfg_done_q, cfg_done_d;
  logic                cfg_error_q, cfg_error_d;
  logic                start_ok;
  logic                hs;
  logic                unused_tail;

  assign unused_tail = ccff_tail;
  assign hs          = bs_valid & bs_ready_q;

`ifdef CCFF_CHECKSUM_EN
  logic [7:0] crc;

  if (WORD_W < 8) begin : g_word_too_narrow
    $error("ccff_chain_loader: CCFF_CHECKSUM_EN requires WORD_W >= 8");
  end

  // The CRC sees exactly the bits the chain sees: the registered head while
  // the registered enable is high.
  ccff_crc8 u_crc (
    .clk     (prog_clk),
    .reset   (prog_reset),
    .clear   (start_ok),
    .bit_in  (ccff_head_q),
    .bit_en  (shift_en_q),
    .crc_out (crc)
  );
`endif

  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    word_left_d = word_left_q;
    word_d      = word_q;
    cfg_error_d = cfg_error_q;
    bs_ready_d  = 1'b0;
    ccff_head_d = 1'b0;
    shift_en_d  = 1'b0;
    start_ok    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cfg_start && cfg_abort) begin
          // abort wins over a simultaneous start
          state_d     = ST_IDLE;
          cfg_error_d = 1'b1;
        end else if (cfg_start) begin
          start_ok    = 1'b1;
          state_d     = ST_FETCH;
          bits_left_d = CNT_W'(CHAIN_LEN);
          cfg_error_d = 1'b0;
          bs_ready_d  = 1'b1;
        end
      end

      ST_FETCH: begin
        bs_ready_d = 1'b1;
        if (hs) begin
          // Present bit 0 during the first SHIFT cycle; keep the rest queued.
          state_d     = ST_SHIFT;
          bs_ready_d  = 1'b0;
          ccff_head_d = bs_data[0];
          shift_en_d  = 1'b1;
          word_d      = bs_data >> 1;
          word_left_d = WL_W'(WORD_W - 1);
          bits_left_d = bits_left_q - CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        // bits_left/word_left count what remains after the bit on the outputs now.
        if (bits_left_q == '0) begin
`ifdef CCFF_CHECKSUM_EN
          state_d    = ST_CHECK;
          bs_ready_d = 1'b1;
`else
          state_d    = ST_DONE;
`endif
        end else if (word_left_q == '0) begin
          state_d    = ST_FETCH;
          bs_ready_d = 1'b1;
        end else begin
          ccff_head_d = word_q[0];
          shift_en_d  = 1'b1;
          word_d      = word_q >> 1;
          word_left_d = word_left_q - WL_W'(1);
          bits_left_d = bits_left_q - CNT_W'(1);
        end
      end

`ifdef CCFF_CHECKSUM_EN
      ST_CHECK: begin
        bs_ready_d = 1'b1;
        if (hs) begin
          state_d    = ST_DONE;
          bs_ready_d = 1'b0;
          if (bs_data[7:0] != crc) cfg_error_d = 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    if (cfg_abort && cfg_busy_q) begin
      state_d     = ST_IDLE;
      bs_ready_d  = 1'b0;
      ccff_head_d = 1'b0;
      shift_en_d  = 1'b0;
      cfg_error_d = 1'b1;
    end

    cfg_busy_d = (state_d == ST_FETCH) || (state_d == ST_SHIFT) ||
                 (state_d == ST_CHECK);
    cfg_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q     <= ST_IDLE;
      bits_left_q <= '0;
      word_left_q <= '0;
      word_q      <= '0;
      bs_ready_q  <= 1'b0;
      ccff_head_q <= 1'b0;
      shift_en_q  <= 1'b0;
      cfg_busy_q  <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      word_left_q <= word_left_d;
      word_q      <= word_d;
      bs_ready_q  <= bs_ready_d;
      ccff_head_q <= ccff_head_d;
      shift_en_q  <= shift_en_d;
      cfg_busy_q  <= cfg_busy_d;
      cfg_done_q  <= cfg_done_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  assign bs_ready  = bs_ready_q;
  assign ccff_head = ccff_head_q;
  assign shift_en  = shift_en_q;
  assign cfg_busy  = cfg_busy_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_error = cfg_error_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader
//   Directed + randomized bench for ccff_chain_loader (CHAIN_LEN=29, WORD_W=8).
//   Expected chain bits come from the word list by plain index arithmetic;
//   the optional CRC word (CCFF_CHECKSUM_EN) comes from polynomial division.
module tb_ccff_chain_loader;
  localparam int CL = 29;
  localparam int WW = 8;
`ifdef CCFF_CHECKSUM_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif

  logic          prog_clk = 1'b0;
  logic          prog_reset = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic          bs_valid = 1'b0;
  logic          ccff_tail = 1'b0;
  logic [WW-1:0] bs_data = '0;
  logic          bs_ready, ccff_head, shift_en, cfg_busy, cfg_done, cfg_error;

  int total = 0;
  int bad   = 0;

  logic [WW-1:0] words [8];
  bit            got [$];
  int            shifts, hs, stall_shift;
  bit            timed_out, err_at_start, busy_at_start;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk  (prog_clk),
    .prog_reset(prog_reset),
    .cfg_start (cfg_start),
    .cfg_abort (cfg_abort),
    .bs_data   (bs_data),
    .bs_valid  (bs_valid),
    .bs_ready  (bs_ready),
    .ccff_head (ccff_head),
    .shift_en  (shift_en),
    .ccff_tail (ccff_tail),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Chain bit k is bit (k mod WW) of word (k div WW).
  function automatic logic [CL-1:0] exp_bits();
    logic [CL-1:0] v;
    logic [WW-1:0] w;
    v = '0;
    for (int k = 0; k < CL; k++) begin
      w    = words[k / WW];
      v[k] = w[k % WW];
    end
    return v;
  endfunction

  function automatic logic [CL-1:0] got_bits();
    logic [CL-1:0] v;
    v = '0;
    for (int k = 0; k < got.size() && k < CL; k++) v[k] = got[k];
    return v;
  endfunction

  // Remainder of M(x)*x^8 mod x^8+x^2+x+1, first shifted bit = highest degree.
  function automatic logic [7:0] crc_ref(input logic [CL-1:0] bits);
    logic [CL+7:0] r;
    r = '0;
    for (int k = 0; k < CL; k++) r[CL+7-k] = bits[k];
    for (int i = CL + 7; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic do_load(input int stall_idx, input int stall_len, input bit rnd,
                         input int start_at, input int abort_at, input int stop_at);
    int idx, stall_cnt;
    bit aborted, restarted, first, stalled, v;
    got.delete();
    shifts = 0; hs = 0; stall_shift = 0; timed_out = 1'b1;
    idx = 0; stall_cnt = 0; aborted = 0; restarted = 0; first = 1; stalled = 0;
    @(negedge prog_clk);
    cfg_start = 1'b1;
    bs_valid  = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge prog_clk);
      if (first) begin
        err_at_start  = cfg_error;
        busy_at_start = cfg_busy;
        first = 0;
      end
      if (shift_en) begin
        got.push_back(ccff_head);
        shifts++;
        if (stalled) stall_shift++;
      end
      if (aborted || cfg_done || (stop_at >= 0 && shifts == stop_at)) begin
        timed_out = 1'b0;
        cfg_abort = 1'b0;
        cfg_start = 1'b0;
        bs_valid  = 1'b0;
        return;
      end
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      if (start_at >= 0 && shifts == start_at && !restarted) begin
        cfg_start = 1'b1;
        restarted = 1;
      end
      if (abort_at >= 0 && shifts == abort_at) begin
        cfg_abort = 1'b1;
        aborted   = 1;
      end
      stalled = 0;
      if (idx == stall_idx && stall_cnt < stall_len && bs_ready) begin
        v = 0;
        stall_cnt++;
        stalled = 1;
      end else if (rnd) begin
        v = ($urandom_range(0, 2) != 0);
      end else begin
        v = 1;
      end
      bs_valid = v;
      bs_data  = v ? words[idx[2:0]] : WW'($urandom);
      if (v && bs_ready) begin
        hs++;
        idx++;
      end
    end
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    bs_valid  = 1'b0;
  endtask

  task automatic set_crc(input logic [7:0] flip);
    words[4] = crc_ref(exp_bits()) ^ flip;
  endtask

  task automatic check_full(input string tag, input bit exp_err);
    chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
    chk({tag, "_shifts"}, 64'(shifts), 64'(CL));
    chk({tag, "_handshakes"}, 64'(hs), 64'(NW));
    chk({tag, "_bits"}, 64'(got_bits()), 64'(exp_bits()));
    chk({tag, "_done_busy_err"}, {61'd0, cfg_done, cfg_busy, cfg_error},
        {61'd0, 1'b1, 1'b0, exp_err});
  endtask

  task automatic check_quiet(input string tag);
    int n;
    n = 0;
    repeat (3) begin
      @(negedge prog_clk);
      if (shift_en || cfg_busy || !cfg_done) n++;
    end
    chk(tag, 64'(n), 64'd0);
  endtask

  initial begin
    // reset state
    #1;
    chk("reset_outputs", {58'd0, bs_ready, ccff_head, shift_en, cfg_busy, cfg_done, cfg_error}, 64'd0);
    @(negedge prog_clk);
    prog_reset = 1'b0;
    @(negedge prog_clk);
    chk("idle_after_reset", {61'd0, bs_ready, shift_en, cfg_busy}, 64'd0);

    // T1: fixed words, always valid
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h12;
    words[4] = 8'h00; words[5] = 8'h00; words[6] = 8'h00; words[7] = 8'h00;
`ifdef CCFF_CHECKSUM_EN
    set_crc(8'h00);
`endif
    do_load(-1, 0, 0, -1, -1, -1);
    chk("t1_busy_at_start", 64'(busy_at_start), 64'd1);
    check_full("t1", 1'b0);
    check_quiet("t1_quiet");

    // T2: 5-cycle valid gap before the second word
    do_load(1, 5, 0, -1, -1, -1);
    check_full("t2", 1'b0);
    chk("t2_stall_shift", 64'(stall_shift), 64'd0);

    // T3: abort after 10 bits, then restart clears the error
    do_load(-1, 0, 0, -1, 10, -1);
    chk("t3_shifts", 64'(shifts), 64'd10);
    chk("t3_abort_state", {59'd0, shift_en, bs_ready, cfg_busy, cfg_done, cfg_error}, 64'd1);
    do_load(-1, 0, 0, -1, -1, -1);
    chk("t3_err_cleared", 64'(err_at_start), 64'd0);
    check_full("t3_reload", 1'b0);

    // T4: start pulse while busy is ignored
    do_load(-1, 0, 0, 12, -1, -1);
    check_full("t4", 1'b0);
    check_quiet("t4_quiet");

    // T5: asynchronous reset mid-shift
    do_load(-1, 0, 0, -1, -1, 14);
    chk("t5_in_shift", {62'd0, shift_en, cfg_busy}, 64'd3);
    #2 prog_reset = 1'b1;
    #1;
    chk("t5_async_reset", {58'd0, bs_ready, ccff_head, shift_en, cfg_busy, cfg_done, cfg_error}, 64'd0);
    @(negedge prog_clk);
    prog_reset = 1'b0;
    @(negedge prog_clk);
    chk("t5_idle_after", {60'd0, bs_ready, shift_en, cfg_busy, cfg_done}, 64'd0);

    // abort and start together in IDLE
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    @(negedge prog_clk);
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    chk("idle_abort_wins", {61'd0, bs_ready, cfg_busy, cfg_error}, 64'd1);
    @(negedge prog_clk);
    chk("idle_abort_stays", {61'd0, bs_ready, cfg_busy, cfg_error}, 64'd1);

    // randomized words, valid gaps and stall positions
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) words[i] = WW'($urandom);
`ifdef CCFF_CHECKSUM_EN
      set_crc(8'h00);
`endif
      do_load(int'($urandom_range(0, NW - 1)), int'($urandom_range(1, 6)), 1, -1, -1, -1);
      check_full($sformatf("rnd%0d", r), 1'b0);
    end

`ifdef CCFF_CHECKSUM_EN
    // T6: corrupted CRC word
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h12;
    set_crc(8'h01);
    do_load(-1, 0, 0, -1, -1, -1);
    check_full("t6_bad_crc", 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
